// File: rtl/div_ratio_ctrl_if.sv
// -----------------------------------------------------------------------------
// div_ratio_ctrl_if
// Ratio-request handshake between a requester (master) and div_ratio_ctrl
// (slave). A request is accepted on a cycle where req_valid && req_ready.
//   req_valid  master -> slave   new ratio request valid
//   req_div    master -> slave   requested divide ratio N (WIDTH bits)
//   req_ready  slave  -> master  request can be accepted this cycle
// -----------------------------------------------------------------------------
interface div_ratio_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req_valid;
    logic [WIDTH-1:0] req_div;
    logic             req_ready;

    modport master (
        output req_valid,
        output req_div,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_div,
        output req_ready
    );
endinterface

// File: rtl/div_ratio_ctrl.sv
// -----------------------------------------------------------------------------
// div_ratio_ctrl
// Programmable clock-enable divider with glitch-free ratio changes. A period
// counter runs 0..cur_div-1; clk_en pulses on the last count of each period and
// div_clk is a registered level, high for the first floor(cur_div/2) counts.
// A new ratio requested mid-period is parked and applied at the period
// boundary so the period in progress is never truncated.
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   asynchronous active-low reset
//   run      in   1 = divider counting, 0 = parked
//   req_if   slave modport of div_ratio_ctrl_if (req_valid, req_div, req_ready)
//   clk_en   out  one-cycle pulse per divided period
//   div_clk  out  registered divided clock level
//   cur_div  out  ratio currently in force
//   busy     out  ratio change pending
//   err      out  (DIV_ZERO_REJECT_EN only) one-cycle pulse on a zero request
//
// Build option: DIV_ZERO_REJECT_EN -- zero requests are accepted but flagged on
// err and otherwise ignored. When undefined, zero requests are clamped to 1.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | parked: cnt=0, no pulses, ratio may be rewritten directly
// RUN   | counting with cur_div; requests taken now or at the wrap
// PEND  | counting; a new ratio waits in pend_q for the period boundary
// -----------------------------------------------------------------------------
module div_ratio_ctrl #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    div_ratio_ctrl_if.slave  req_if,
    output logic             clk_en,
    output logic             div_clk,
    output logic [WIDTH-1:0] cur_div,
    output logic             busy
`ifdef DIV_ZERO_REJECT_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] DEF_VAL = WIDTH'(DEF_DIV);

    state_t           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cur_div_q;
    logic [WIDTH-1:0] pend_q;
    logic             div_clk_q;
    logic             busy_q;
`ifdef DIV_ZERO_REJECT_EN
    logic             err_q;
`endif

    logic             ready;
    logic             accept;
    logic             req_zero;
    logic             take;
    logic [WIDTH-1:0] req_ratio;
    logic             wrap;
    logic [WIDTH-1:0] cnt_inc;

    // High phase covers counts 0..floor(d/2)-1; d==1 gives an empty high phase.
    function automatic logic hi_phase(input logic [WIDTH-1:0] c,
                                      input logic [WIDTH-1:0] d);
        return c < (d >> 1);
    endfunction

    assign ready    = (state_q != PEND);
    assign accept   = req_if.req_valid && ready;
    assign req_zero = (req_if.req_div == '0);
    assign wrap     = (cnt_q == cur_div_q - ONE);
    assign cnt_inc  = cnt_q + ONE;

`ifdef DIV_ZERO_REJECT_EN
    // A zero request completes the handshake but changes nothing.
    assign take      = accept && !req_zero;
    assign req_ratio = req_if.req_div;
`else
    assign take      = accept;
    assign req_ratio = req_zero ? ONE : req_if.req_div;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_div_q <= DEF_VAL;
            pend_q    <= '0;
            div_clk_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (take) begin
                        cur_div_q <= req_ratio;
                    end
                    if (run) begin
                        state_q   <= RUN;
                        div_clk_q <= hi_phase('0, take ? req_ratio : cur_div_q);
                    end else begin
                        div_clk_q <= 1'b0;
                    end
                end

                RUN: begin
                    if (!run) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        div_clk_q <= 1'b0;
                        if (take) begin
                            cur_div_q <= req_ratio;
                        end
                    end else if (wrap) begin
                        // Boundary: a request here takes effect for the next
                        // period without ever entering PEND.
                        cnt_q     <= '0;
                        cur_div_q <= take ? req_ratio : cur_div_q;
                        div_clk_q <= hi_phase('0, take ? req_ratio : cur_div_q);
                    end else begin
                        cnt_q     <= cnt_inc;
                        div_clk_q <= hi_phase(cnt_inc, cur_div_q);
                        if (take) begin
                            pend_q  <= req_ratio;
                            state_q <= PEND;
                            busy_q  <= 1'b1;
                        end
                    end
                end

                PEND: begin
                    if (!run) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        cur_div_q <= pend_q;
                        div_clk_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (wrap) begin
                        state_q   <= RUN;
                        cnt_q     <= '0;
                        cur_div_q <= pend_q;
                        div_clk_q <= hi_phase('0, pend_q);
                        busy_q    <= 1'b0;
                    end else begin
                        cnt_q     <= cnt_inc;
                        div_clk_q <= hi_phase(cnt_inc, cur_div_q);
                    end
                end

                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    div_clk_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef DIV_ZERO_REJECT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && req_zero;
        end
    end

    assign err = err_q;
`endif

    // clk_en follows the live run input so a stop on the last count does not
    // emit a pulse for a period that will not be completed.
    assign clk_en           = (state_q != IDLE) && run && wrap;
    assign div_clk          = div_clk_q;
    assign cur_div          = cur_div_q;
    assign busy             = busy_q;
    assign req_if.req_ready = ready;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ratio_ctrl
// Scoreboard bench for div_ratio_ctrl. The driver applies inputs on the falling
// edge, asks a period-level reference model what the outputs must be during
// that cycle, queues the expectation and advances the model across the next
// rising edge. A separate monitor pops one expectation per cycle and compares.
// Honors DIV_ZERO_REJECT_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_div_ratio_ctrl;

    localparam int W = 8;

    typedef struct {
        logic       clk_en;
        logic       div_clk;
        logic       busy;
        logic       ready;
        logic       err;
        logic [7:0] cur_div;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst;
    logic run;
    logic clk_en;
    logic div_clk;
    logic [W-1:0] cur_div;
    logic busy;
`ifdef DIV_ZERO_REJECT_EN
    logic err;
`endif

    div_ratio_ctrl_if #(.WIDTH(W)) bus ();

    div_ratio_ctrl #(.WIDTH(W), .DEF_DIV(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .req_if  (bus.slave),
        .clk_en  (clk_en),
        .div_clk (div_clk),
        .cur_div (cur_div),
        .busy    (busy)
`ifdef DIV_ZERO_REJECT_EN
        ,
        .err     (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    exp_t exp_q[$];

    // Reference model: whether the divider is running, position inside the
    // current period, the ratio in force, and an optional queued ratio.
    bit m_running;
    int m_pos;
    int m_ratio;
    bit m_has_pend;
    int m_pend_ratio;
    bit m_err;

    task automatic model_reset();
        m_running    = 0;
        m_pos        = 0;
        m_ratio      = 2;
        m_has_pend   = 0;
        m_pend_ratio = 0;
        m_err        = 0;
    endtask

    task automatic model_advance(input bit run_v, input bit vld, input int div);
        bit accept;
        bit apply;
        int nv;
        accept = vld && !m_has_pend;
`ifdef DIV_ZERO_REJECT_EN
        apply = accept && (div != 0);
        nv    = div;
`else
        apply = accept;
        nv    = (div == 0) ? 1 : div;
`endif
        m_err = accept && (div == 0);
        if (!m_running) begin
            if (apply) m_ratio = nv;
            m_pos     = 0;
            m_running = run_v;
        end else if (!run_v) begin
            m_running = 0;
            m_pos     = 0;
            if (m_has_pend) begin
                m_ratio    = m_pend_ratio;
                m_has_pend = 0;
            end else if (apply) begin
                m_ratio = nv;
            end
        end else if (m_pos == m_ratio - 1) begin
            m_pos = 0;
            if (m_has_pend) begin
                m_ratio    = m_pend_ratio;
                m_has_pend = 0;
            end else if (apply) begin
                m_ratio = nv;
            end
        end else begin
            m_pos = m_pos + 1;
            if (apply) begin
                m_has_pend   = 1;
                m_pend_ratio = nv;
            end
        end
    endtask

    task automatic step(input bit rst_v, input bit run_v, input bit vld, input int div);
        exp_t e;
        @(negedge clk);
        rst           = rst_v;
        run           = run_v;
        bus.req_valid = vld;
        bus.req_div   = W'(div);
        if (!rst_v) model_reset();
        e.clk_en  = m_running && run_v && (m_pos == m_ratio - 1);
        e.div_clk = m_running && (m_pos < m_ratio / 2);
        e.busy    = m_has_pend;
        e.ready   = !m_has_pend;
        e.err     = m_err;
        e.cur_div = 8'(m_ratio);
        e.cyc     = cyc;
        exp_q.push_back(e);
        if (rst_v) model_advance(run_v, vld, div);
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req, input int c);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, c, act, req);
        end
    endtask

    exp_t mon_e;
    always begin
        @(negedge clk);
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("clk_en",    32'(clk_en),        32'(mon_e.clk_en),  mon_e.cyc);
            chk("div_clk",   32'(div_clk),       32'(mon_e.div_clk), mon_e.cyc);
            chk("cur_div",   32'(cur_div),       32'(mon_e.cur_div), mon_e.cyc);
            chk("busy",      32'(busy),          32'(mon_e.busy),    mon_e.cyc);
            chk("req_ready", 32'(bus.req_ready), 32'(mon_e.ready),   mon_e.cyc);
`ifdef DIV_ZERO_REJECT_EN
            chk("err",       32'(err),           32'(mon_e.err),     mon_e.cyc);
`endif
        end
    end

    // Run with ratio r from idle: stop, load r, start.
    task automatic start_with(input int r);
        step(1, 0, 0, 0);
        step(1, 0, 1, r);
        step(1, 1, 0, 0);
    endtask

    task automatic run_to_pos(input int p);
        for (int i = 0; i < 300 && m_pos != p; i++) step(1, 1, 0, 0);
    endtask

    initial begin
        int r_div;
        bit r_vld;
        bit r_run;
        bit r_rst;
        rst           = 1'b0;
        run           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_div   = '0;
        model_reset();

        repeat (3) step(0, 0, 0, 0);

        // Default ratio 2 after reset.
        repeat (10) step(1, 1, 0, 0);
        repeat (2) step(1, 0, 0, 0);

        // Load 5 while parked, then run.
        step(1, 0, 1, 5);
        step(1, 0, 0, 0);
        repeat (16) step(1, 1, 0, 0);

        // Running 4, request 3 mid-period.
        start_with(4);
        run_to_pos(1);
        step(1, 1, 1, 3);
        repeat (12) step(1, 1, 0, 0);

        // Running 4, request 6 on the wrap.
        start_with(4);
        run_to_pos(3);
        step(1, 1, 1, 6);
        repeat (14) step(1, 1, 0, 0);

        // Pending 8 -> 2, then stop.
        start_with(8);
        run_to_pos(2);
        step(1, 1, 1, 2);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0);

        // Reset while pending discards the queued ratio.
        start_with(8);
        run_to_pos(2);
        step(1, 1, 1, 5);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        repeat (6) step(1, 1, 0, 0);

        // Zero request while running at the wrap, and from idle.
        run_to_pos(1);
        step(1, 1, 1, 0);
        repeat (8) step(1, 1, 0, 0);
        step(1, 0, 1, 0);
        repeat (8) step(1, 1, 0, 0);

        // Ratio 1 boundary, then widest ratio.
        start_with(1);
        repeat (6) step(1, 1, 0, 0);
        start_with(255);
        repeat (260) step(1, 1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            r_rst = ($urandom_range(0, 299) != 0);
            r_run = ($urandom_range(0, 19) != 0);
            r_vld = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) == 0) r_div = 0;
            else if ($urandom_range(0, 49) == 0) r_div = $urandom_range(13, 40);
            else r_div = $urandom_range(1, 12);
            step(r_rst, r_run, r_vld, r_div);
        end

        step(1, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #5;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0, cyc);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
